cluster_unpacker1536: RTL and testbench

Reconstructs the 1536-strip hit bitmap from the 8 cluster words (11-bit address, 3-bit count) that the first-8-of-1536 cluster finder produces each frame. It sits at the receive end of the cluster link, in the emulator and the self-check path, and returns the cluster list to a `vpfs` bitmap. The bench compares that bitmap against the truncated input of the packer. It processes two clusters per `clock4x` cycle over four cycles per frame and publishes one bitmap per frame with a valid strobe.

---
 rtl/cluster_unpacker1536.sv | 183 ++++++++++++++++++
 tb/tb_cluster_unpacker1536.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_unpacker1536.sv
// Rebuilds the 1536-strip hit bitmap from eight (address, count) cluster words.
// Two slots are expanded per clock4x cycle. The bitmap publishes with a one-cycle valid pulse.
module cluster_unpacker1536 #(
  parameter int MXADRBITS = 11,
  parameter int MXCNTBITS = 3,
  parameter int MXSTRIPS  = 1536,
  parameter int HALF      = 768
) (
  input  logic                 clock4x,
  input  logic                 reset_n,
  input  logic                 frame_clock,
  input  logic [MXADRBITS-1:0] adr0,
  input  logic [MXADRBITS-1:0] adr1,
  input  logic [MXADRBITS-1:0] adr2,
  input  logic [MXADRBITS-1:0] adr3,
  input  logic [MXADRBITS-1:0] adr4,
  input  logic [MXADRBITS-1:0] adr5,
  input  logic [MXADRBITS-1:0] adr6,
  input  logic [MXADRBITS-1:0] adr7,
  input  logic [MXCNTBITS-1:0] cnt0,
  input  logic [MXCNTBITS-1:0] cnt1,
  input  logic [MXCNTBITS-1:0] cnt2,
  input  logic [MXCNTBITS-1:0] cnt3,
  input  logic [MXCNTBITS-1:0] cnt4,
  input  logic [MXCNTBITS-1:0] cnt5,
  input  logic [MXCNTBITS-1:0] cnt6,
  input  logic [MXCNTBITS-1:0] cnt7,
  output logic [MXSTRIPS-1:0]  vpfs_out,
  output logic                 valid,
  output logic [3:0]           nclusters,
  output logic                 err_adr,
  output logic                 overrun
);

  localparam int RUNW = 1 << MXCNTBITS;
  localparam logic [MXADRBITS-1:0] EMPTY_ADR  = {MXADRBITS{1'b1}};
  localparam logic [MXADRBITS-1:0] STRIPS_ADR = MXADRBITS'(MXSTRIPS);
  localparam logic [MXADRBITS-1:0] HALF_ADR   = MXADRBITS'(HALF);
  localparam logic [MXSTRIPS-1:0]  LOW_MASK   = {{(MXSTRIPS-HALF){1'b0}}, {HALF{1'b1}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4
  } state_t;

  // Upper-half clusters clip naturally at the top of the shifted vector; lower-half ones need the mask.
  function automatic logic [MXSTRIPS-1:0] slot_mask(input logic [MXADRBITS-1:0] a,
                                                    input logic [MXCNTBITS-1:0] c);
    logic [MXSTRIPS-1:0] run;
    logic [MXSTRIPS-1:0] m;
    run = '0;
    for (int i = 0; i < RUNW; i++) begin
      run[i] = (i <= int'(c));
    end
    m = run << a;
    if (a >= STRIPS_ADR) begin
      m = '0;
    end else if (a < HALF_ADR) begin
      m = m & LOW_MASK;
    end else begin
      m = m;
    end
    return m;
  endfunction

  state_t               state_q;
  logic                 fc_q;
  logic                 armed_q;
  logic [MXSTRIPS-1:0]  acc_q;
  logic [3:0]           ncl_q;
  logic                 err_q;
  logic [MXADRBITS-1:0] adr_q [8];
  logic [MXCNTBITS-1:0] cnt_q [8];

  logic [MXADRBITS-1:0] adr_in_s [8];
  logic [MXCNTBITS-1:0] cnt_in_s [8];
  logic                 frame_edge_s;
  logic [1:0]           pair_s;
  logic [MXADRBITS-1:0] adr_a_s, adr_b_s;
  logic [MXCNTBITS-1:0] cnt_a_s, cnt_b_s;
  logic                 legal_a_s, legal_b_s, ill_a_s, ill_b_s;
  logic [MXSTRIPS-1:0]  acc_d;
  logic [3:0]           ncl_d;
  logic                 err_d;

  assign adr_in_s = '{adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7};
  assign cnt_in_s = '{cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7};

  // armed_q blocks a frame_clock that is already high when reset releases from counting as an edge.
  assign frame_edge_s = frame_clock & ~fc_q & armed_q;

  // Expand the slot pair owned by the current phase and fold it into the running tallies.
  always_comb begin
    case (state_q)
      P0:      pair_s = 2'd0;
      P1:      pair_s = 2'd1;
      P2:      pair_s = 2'd2;
      P3:      pair_s = 2'd3;
      default: pair_s = 2'd0;
    endcase
    adr_a_s   = adr_q[{pair_s, 1'b0}];
    adr_b_s   = adr_q[{pair_s, 1'b1}];
    cnt_a_s   = cnt_q[{pair_s, 1'b0}];
    cnt_b_s   = cnt_q[{pair_s, 1'b1}];
    legal_a_s = (adr_a_s < STRIPS_ADR);
    legal_b_s = (adr_b_s < STRIPS_ADR);
    ill_a_s   = !legal_a_s && (adr_a_s != EMPTY_ADR);
    ill_b_s   = !legal_b_s && (adr_b_s != EMPTY_ADR);
    acc_d     = acc_q | slot_mask(adr_a_s, cnt_a_s) | slot_mask(adr_b_s, cnt_b_s);
    ncl_d     = ncl_q + {3'b000, legal_a_s} + {3'b000, legal_b_s};
    err_d     = err_q | ill_a_s | ill_b_s;
  end

  // Frame sequencer. A new edge always wins and restarts at P0, even while the P3 publish is happening.
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      fc_q      <= 1'b0;
      armed_q   <= 1'b0;
      acc_q     <= '0;
      ncl_q     <= 4'd0;
      err_q     <= 1'b0;
      vpfs_out  <= '0;
      valid     <= 1'b0;
      nclusters <= 4'd0;
      err_adr   <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        adr_q[i] <= EMPTY_ADR;
        cnt_q[i] <= '0;
      end
    end else begin
      fc_q    <= frame_clock;
      armed_q <= armed_q | ~frame_clock;
      valid   <= 1'b0;
      overrun <= 1'b0;
      case (state_q)
        IDLE: state_q <= IDLE;
        P0: begin
          acc_q   <= acc_d;
          ncl_q   <= ncl_d;
          err_q   <= err_d;
          state_q <= P1;
        end
        P1: begin
          acc_q   <= acc_d;
          ncl_q   <= ncl_d;
          err_q   <= err_d;
          state_q <= P2;
        end
        P2: begin
          acc_q   <= acc_d;
          ncl_q   <= ncl_d;
          err_q   <= err_d;
          state_q <= P3;
        end
        P3: begin
          vpfs_out  <= acc_d;
          nclusters <= ncl_d;
          err_adr   <= err_d;
          valid     <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (frame_edge_s) begin
        for (int i = 0; i < 8; i++) begin
          adr_q[i] <= adr_in_s[i];
          cnt_q[i] <= cnt_in_s[i];
        end
        acc_q   <= '0;
        ncl_q   <= 4'd0;
        err_q   <= 1'b0;
        state_q <= P0;
        overrun <= (state_q == P0) || (state_q == P1) || (state_q == P2);
      end
    end
  end

endmodule

// File: tb/tb_cluster_unpacker1536.sv
// Directed bench for cluster_unpacker1536: a table of single frames plus back-to-back,
// overrun and mid-frame reset sequences.
module tb_cluster_unpacker1536;

  typedef struct packed {
    logic [7:0][10:0] adr;
    logic [7:0][2:0]  cnt;
    logic [7:0][10:0] lo;
    logic [7:0][10:0] hi;
    logic [3:0]       nr;
    logic [3:0]       ncl;
    logic             err;
  } vec_t;

  logic          clock4x = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_clock = 1'b0;
  logic [10:0]   adr [8];
  logic [2:0]    cnt [8];
  logic [1535:0] vpfs_out;
  logic          valid;
  logic [3:0]    nclusters;
  logic          err_adr;
  logic          overrun;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [7];
  vec_t fr [3];

  always #5 clock4x = ~clock4x;

  cluster_unpacker1536 dut (
    .clock4x(clock4x), .reset_n(reset_n), .frame_clock(frame_clock),
    .adr0(adr[0]), .adr1(adr[1]), .adr2(adr[2]), .adr3(adr[3]),
    .adr4(adr[4]), .adr5(adr[5]), .adr6(adr[6]), .adr7(adr[7]),
    .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]), .cnt3(cnt[3]),
    .cnt4(cnt[4]), .cnt5(cnt[5]), .cnt6(cnt[6]), .cnt7(cnt[7]),
    .vpfs_out(vpfs_out), .valid(valid), .nclusters(nclusters),
    .err_adr(err_adr), .overrun(overrun)
  );

  task automatic set_empty(output vec_t v);
    v.adr = {8{11'h7FF}};
    v.cnt = '0;
    v.lo  = '0;
    v.hi  = '0;
    v.nr  = 4'd0;
    v.ncl = 4'd0;
    v.err = 1'b0;
  endtask

  task automatic set_slot(inout vec_t v, input int s, input int a, input int c);
    v.adr[s] = 11'(a);
    v.cnt[s] = 3'(c);
  endtask

  task automatic add_rng(inout vec_t v, input int lo, input int hi);
    v.lo[v.nr] = 11'(lo);
    v.hi[v.nr] = 11'(hi);
    v.nr = v.nr + 4'd1;
  endtask

  function automatic logic [1535:0] exp_map(input vec_t v);
    logic [1535:0] m;
    m = '0;
    for (int r = 0; r < 8; r++) begin
      if (r < int'(v.nr)) begin
        for (int b = int'(v.lo[r]); b <= int'(v.hi[r]); b++) m[b] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_map(input string name, input logic [1535:0] exp);
    int first;
    checks++;
    if (vpfs_out !== exp) begin
      errors++;
      first = -1;
      for (int b = 1535; b >= 0; b--) if (vpfs_out[b] !== exp[b]) first = b;
      $display("FAIL %s: got %0d bits set, expected %0d bits set, first differing strip %0d",
               name, $countones(vpfs_out), $countones(exp), first);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      adr[i] = v.adr[i];
      cnt[i] = v.cnt[i];
    end
  endtask

  task automatic garbage();
    for (int i = 0; i < 8; i++) begin
      adr[i] = 11'($urandom_range(0, 2047));
      cnt[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // One isolated frame: edge, latency to valid, contents, pulse width.
  task automatic run_frame(input vec_t v, input string name);
    int lat;
    bit found;
    bit ovr;
    @(negedge clock4x);
    frame_clock = 1'b0;
    garbage();
    @(negedge clock4x);
    frame_clock = 1'b1;
    apply_vec(v);
    lat = 0;
    found = 1'b0;
    ovr = 1'b0;
    for (int t = 1; t <= 12 && !found; t++) begin
      @(negedge clock4x);
      if (t == 1) begin
        frame_clock = 1'b0;
        garbage();
      end
      if (overrun) ovr = 1'b1;
      if (valid) begin
        found = 1'b1;
        lat = t;
      end
    end
    chk_int({name, "_latency"}, lat, 5);
    chk_map({name, "_map"}, exp_map(v));
    chk_int({name, "_ncl"}, int'(nclusters), int'(v.ncl));
    chk_int({name, "_err"}, int'(err_adr), int'(v.err));
    chk_int({name, "_no_overrun"}, int'(ovr), 0);
    @(negedge clock4x);
    chk_int({name, "_valid_pulse"}, int'(valid), 0);
  endtask

  initial begin
    logic [1535:0] prev;
    int vcount;

    for (int i = 0; i < 7; i++) set_empty(vecs[i]);
    set_slot(vecs[0], 0, 5, 2);       add_rng(vecs[0], 5, 7);        vecs[0].ncl = 4'd1;
    set_slot(vecs[1], 0, 766, 7);     set_slot(vecs[1], 1, 1533, 4);
    add_rng(vecs[1], 766, 767);       add_rng(vecs[1], 1533, 1535);  vecs[1].ncl = 4'd2;
    set_slot(vecs[2], 0, 100, 3);     set_slot(vecs[2], 1, 102, 3);  set_slot(vecs[2], 2, 0, 0);
    set_slot(vecs[2], 3, 767, 1);     set_slot(vecs[2], 4, 768, 2);  set_slot(vecs[2], 5, 1000, 7);
    set_slot(vecs[2], 6, 1535, 0);    set_slot(vecs[2], 7, 400, 5);
    add_rng(vecs[2], 100, 105);       add_rng(vecs[2], 0, 0);        add_rng(vecs[2], 767, 767);
    add_rng(vecs[2], 768, 770);       add_rng(vecs[2], 1000, 1007);  add_rng(vecs[2], 1535, 1535);
    add_rng(vecs[2], 400, 405);       vecs[2].ncl = 4'd8;
    set_slot(vecs[4], 3, 1600, 2);    vecs[4].err = 1'b1;
    set_slot(vecs[5], 0, 1536, 1);    set_slot(vecs[5], 5, 2046, 3); set_slot(vecs[5], 7, 10, 0);
    add_rng(vecs[5], 10, 10);         vecs[5].ncl = 4'd1;            vecs[5].err = 1'b1;
    set_slot(vecs[6], 2, 767, 3);     set_slot(vecs[6], 4, 768, 0);  set_slot(vecs[6], 6, 0, 7);
    add_rng(vecs[6], 767, 767);       add_rng(vecs[6], 768, 768);    add_rng(vecs[6], 0, 7);
    vecs[6].ncl = 4'd3;
    fr[0] = vecs[2];
    fr[1] = vecs[0];
    fr[2] = vecs[1];

    garbage();
    repeat (3) @(negedge clock4x);
    chk_int("reset_valid", int'(valid), 0);
    chk_map("reset_map", '0);
    chk_int("reset_ncl", int'(nclusters), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames with a 4-cycle frame_clock.
    for (int t = 0; t <= 16; t++) begin
      @(negedge clock4x);
      if (t >= 1) begin
        chk_int($sformatf("nom_valid_t%0d", t), int'(valid), int'(t == 5 || t == 9 || t == 13));
        chk_int($sformatf("nom_overrun_t%0d", t), int'(overrun), 0);
        if (t == 5 || t == 9 || t == 13) begin
          chk_map($sformatf("nom_map_t%0d", t), exp_map(fr[(t - 5) / 4]));
          chk_int($sformatf("nom_ncl_t%0d", t), int'(nclusters), int'(fr[(t - 5) / 4].ncl));
        end
      end
      frame_clock = (t < 12) && ((t % 4) < 2);
      if ((t % 4) == 0 && t < 12) apply_vec(fr[t / 4]);
      else garbage();
    end

    // Overrun: second edge two cycles after the first.
    run_frame(vecs[0], "pre_ovr");
    prev = exp_map(vecs[0]);
    @(negedge clock4x);
    frame_clock = 1'b1;
    apply_vec(vecs[1]);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clock4x);
      chk_int($sformatf("ovr_overrun_t%0d", t), int'(overrun), int'(t == 3));
      chk_int($sformatf("ovr_valid_t%0d", t), int'(valid), int'(t == 7));
      if (t < 7) chk_map($sformatf("ovr_hold_t%0d", t), prev);
      else begin
        chk_map("ovr_new_map", exp_map(vecs[6]));
        chk_int("ovr_new_ncl", int'(nclusters), int'(vecs[6].ncl));
      end
      if (t == 2) begin
        frame_clock = 1'b1;
        apply_vec(vecs[6]);
      end else begin
        frame_clock = 1'b0;
        garbage();
      end
    end

    // Reset asserted while the frame is in P1.
    @(negedge clock4x);
    frame_clock = 1'b1;
    apply_vec(vecs[2]);
    @(negedge clock4x);
    frame_clock = 1'b0;
    garbage();
    @(negedge clock4x);
    reset_n = 1'b0;
    #1;
    chk_map("rst_map", '0);
    chk_int("rst_valid", int'(valid), 0);
    chk_int("rst_ncl", int'(nclusters), 0);
    chk_int("rst_err", int'(err_adr), 0);
    chk_int("rst_overrun", int'(overrun), 0);
    frame_clock = 1'b1;
    repeat (2) @(negedge clock4x);
    reset_n = 1'b1;
    vcount = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clock4x);
      if (valid || overrun) vcount++;
    end
    chk_int("rst_no_activity", vcount, 0);
    chk_map("rst_map_idle", '0);
    run_frame(vecs[1], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
